pe_loop_sequencer: RTL and testbench

- Sequences one PE's MAC schedule as a 3-deep loop nest: output column p (outer), input channel c (middle) and filter tap k (inner).
- Emits one spad read command per beat (filter, ifmap, psum addresses plus accumulate flags) to the PE datapath under a valid/ready handshake.
- Loop bounds are programmed as last-index values, so a loop runs while count < bound and finishes when count >= bound.
- Sits between the PE-array config/global controller (start/done) and the PE's scratchpads/MAC.

---
 rtl/pe_loop_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_pe_loop_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_loop_sequencer.sv
// ---------------------------------------------------------------------------
// pe_loop_sequencer
//
// Walks one PE's MAC schedule as a three-deep loop nest (output column p
// outer, input channel c middle, filter tap k inner) and issues one spad
// read command per beat to the PE datapath over a valid/ready handshake.
// Loop bounds are last-index values: a loop keeps stepping while
// count < last and wraps once count >= last.
//
// Optional build macro: PE_SEQ_ABORT_EN adds abort_i, which returns a
// running schedule to IDLE without a done pulse.
//
// Ports
//   clk            clock
//   rstn           synchronous active-low reset
//   start_i        begin a schedule (sampled only in IDLE)
//   abort_i        cancel a running schedule (PE_SEQ_ABORT_EN only)
//   cfg_k_last_i   last filter-tap index
//   cfg_c_last_i   last channel index
//   cfg_p_last_i   last output-column index
//   cfg_ifw_i      ifmap row pitch per channel
//   busy_o         high in RUN and DONE
//   done_o         one-cycle pulse after the final beat
//   out_valid_o    command valid
//   out_ready_i    datapath accepts command
//   filt_addr_o    filter spad address
//   ifmap_addr_o   ifmap spad address
//   psum_addr_o    psum spad address
//   acc_first_o    first MAC of this psum (load instead of add)
//   acc_last_o     last MAC of this psum (write psum back)
//
// State | Meaning
//   IDLE | waiting for start, outputs zero
//   RUN  | presenting commands, advancing on each beat
//   DONE | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module pe_loop_sequencer #(
    parameter int CW = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
`ifdef PE_SEQ_ABORT_EN
    input  logic          abort_i,
`endif
    input  logic [CW-1:0] cfg_k_last_i,
    input  logic [CW-1:0] cfg_c_last_i,
    input  logic [CW-1:0] cfg_p_last_i,
    input  logic [AW-1:0] cfg_ifw_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] filt_addr_o,
    output logic [AW-1:0] ifmap_addr_o,
    output logic [AW-1:0] psum_addr_o,
    output logic          acc_first_o,
    output logic          acc_last_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;

    // shadow copies of the configuration, frozen for the whole schedule
    logic [CW-1:0] k_last_q, k_last_d;
    logic [CW-1:0] c_last_q, c_last_d;
    logic [CW-1:0] p_last_q, p_last_d;
    logic [AW-1:0] ifw_q,    ifw_d;

    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] p_q, p_d;
    logic [AW-1:0] filt_ptr_q, filt_ptr_d;
    logic [AW-1:0] c_base_q,   c_base_d;

    logic [AW-1:0] filt_addr_q,  filt_addr_d;
    logic [AW-1:0] ifmap_addr_q, ifmap_addr_d;
    logic [AW-1:0] psum_addr_q,  psum_addr_d;
    logic          acc_first_q,  acc_first_d;
    logic          acc_last_q,   acc_last_d;

    logic          abort_w;
    logic          beat;
    logic          k_end, c_end, p_end;

`ifdef PE_SEQ_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    assign beat  = (state_q == S_RUN) && out_ready_i;
    assign k_end = (k_q >= k_last_q);
    assign c_end = (c_q >= c_last_q);
    assign p_end = (p_q >= p_last_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            k_last_q     <= '0;
            c_last_q     <= '0;
            p_last_q     <= '0;
            ifw_q        <= '0;
            k_q          <= '0;
            c_q          <= '0;
            p_q          <= '0;
            filt_ptr_q   <= '0;
            c_base_q     <= '0;
            filt_addr_q  <= '0;
            ifmap_addr_q <= '0;
            psum_addr_q  <= '0;
            acc_first_q  <= 1'b0;
            acc_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_last_q     <= k_last_d;
            c_last_q     <= c_last_d;
            p_last_q     <= p_last_d;
            ifw_q        <= ifw_d;
            k_q          <= k_d;
            c_q          <= c_d;
            p_q          <= p_d;
            filt_ptr_q   <= filt_ptr_d;
            c_base_q     <= c_base_d;
            filt_addr_q  <= filt_addr_d;
            ifmap_addr_q <= ifmap_addr_d;
            psum_addr_q  <= psum_addr_d;
            acc_first_q  <= acc_first_d;
            acc_last_q   <= acc_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_last_d     = k_last_q;
        c_last_d     = c_last_q;
        p_last_d     = p_last_q;
        ifw_d        = ifw_q;
        k_d          = k_q;
        c_d          = c_q;
        p_d          = p_q;
        filt_ptr_d   = filt_ptr_q;
        c_base_d     = c_base_q;
        filt_addr_d  = filt_addr_q;
        ifmap_addr_d = ifmap_addr_q;
        psum_addr_d  = psum_addr_q;
        acc_first_d  = acc_first_q;
        acc_last_d   = acc_last_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_RUN;
                    k_last_d     = cfg_k_last_i;
                    c_last_d     = cfg_c_last_i;
                    p_last_d     = cfg_p_last_i;
                    ifw_d        = cfg_ifw_i;
                    k_d          = '0;
                    c_d          = '0;
                    p_d          = '0;
                    filt_ptr_d   = '0;
                    c_base_d     = '0;
                    // first command is (p,c,k) = (0,0,0)
                    filt_addr_d  = '0;
                    ifmap_addr_d = '0;
                    psum_addr_d  = '0;
                    acc_first_d  = 1'b1;
                    acc_last_d   = (cfg_k_last_i == '0) && (cfg_c_last_i == '0);
                end
            end

            S_RUN: begin
                if (abort_w || (beat && k_end && c_end && p_end)) begin
                    // abort wins over a coincident beat; both leave the
                    // counters and the command bus cleared
                    state_d      = abort_w ? S_IDLE : S_DONE;
                    k_d          = '0;
                    c_d          = '0;
                    p_d          = '0;
                    filt_ptr_d   = '0;
                    c_base_d     = '0;
                    filt_addr_d  = '0;
                    ifmap_addr_d = '0;
                    psum_addr_d  = '0;
                    acc_first_d  = 1'b0;
                    acc_last_d   = 1'b0;
                end else if (beat) begin
                    if (!k_end) begin
                        k_d = k_q + 1'b1;
                    end else begin
                        k_d = '0;
                        if (!c_end) begin
                            c_d      = c_q + 1'b1;
                            c_base_d = c_base_q + ifw_q;
                        end else begin
                            c_d      = '0;
                            c_base_d = '0;
                            p_d      = p_q + 1'b1;
                        end
                    end
                    // filter pointer restarts at each new output column
                    filt_ptr_d   = (k_end && c_end) ? '0 : filt_ptr_q + 1'b1;

                    filt_addr_d  = filt_ptr_d;
                    ifmap_addr_d = c_base_d + AW'(p_d) + AW'(k_d);
                    psum_addr_d  = AW'(p_d);
                    acc_first_d  = (k_d == '0) && (c_d == '0);
                    acc_last_d   = (k_d == k_last_q) && (c_d == c_last_q);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid_o  = (state_q == S_RUN);
    assign busy_o       = (state_q == S_RUN) || (state_q == S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign filt_addr_o  = filt_addr_q;
    assign ifmap_addr_o = ifmap_addr_q;
    assign psum_addr_o  = psum_addr_q;
    assign acc_first_o  = acc_first_q;
    assign acc_last_o   = acc_last_q;

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_loop_sequencer
//
// Scoreboard bench for pe_loop_sequencer. Stimulus pushes hand-computed
// command vectors into a queue before starting a schedule; a monitor on the
// falling edge compares every presented command against the queue head and
// pops it when the beat is accepted. Done timing is checked against the
// final-beat marker of the popped vector.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pe_loop_sequencer;

    localparam int CW = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_r = 1'b0;
    logic [CW-1:0] cfg_k_last_i = '0;
    logic [CW-1:0] cfg_c_last_i = '0;
    logic [CW-1:0] cfg_p_last_i = '0;
    logic [AW-1:0] cfg_ifw_i = '0;
    logic          busy_o, done_o, out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [AW-1:0] filt_addr_o, ifmap_addr_o, psum_addr_o;
    logic          acc_first_o, acc_last_o;

    pe_loop_sequencer #(.CW(CW), .AW(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
`ifdef PE_SEQ_ABORT_EN
        .abort_i      (abort_r),
`endif
        .cfg_k_last_i (cfg_k_last_i),
        .cfg_c_last_i (cfg_c_last_i),
        .cfg_p_last_i (cfg_p_last_i),
        .cfg_ifw_i    (cfg_ifw_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .filt_addr_o  (filt_addr_o),
        .ifmap_addr_o (ifmap_addr_o),
        .psum_addr_o  (psum_addr_o),
        .acc_first_o  (acc_first_o),
        .acc_last_o   (acc_last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] filt;
        logic [AW-1:0] ifmap;
        logic [AW-1:0] psum;
        logic          af;
        logic          al;
        logic          fin;
    } cmd_t;

    cmd_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   beats_seen = 0;
    logic fin_prev = 1'b0;

    // k_last=2, c_last=1, p_last=1, ifw=16: hand-computed ifmap addresses
    logic [AW-1:0] std_ifmap [12] = '{8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18,
                                      8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_std();
        cmd_t c;
        for (int i = 0; i < 12; i++) begin
            c.filt  = AW'(i % 6);
            c.ifmap = std_ifmap[i];
            c.psum  = AW'(i / 6);
            c.af    = (i % 6) == 0;
            c.al    = (i % 6) == 5;
            c.fin   = (i == 11);
            q.push_back(c);
        end
    endtask

    task automatic push_one_beat();
        cmd_t c;
        c.filt = '0; c.ifmap = '0; c.psum = '0;
        c.af = 1'b1; c.al = 1'b1; c.fin = 1'b1;
        q.push_back(c);
    endtask

    task automatic do_start(input logic [CW-1:0] kl, input logic [CW-1:0] cl,
                            input logic [CW-1:0] pl, input logic [AW-1:0] ifw);
        @(posedge clk); #1;
        cfg_k_last_i = kl; cfg_c_last_i = cl; cfg_p_last_i = pl; cfg_ifw_i = ifw;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("valid_after_start", out_valid_o, 1);
    endtask

    task automatic run_to_idle(input logic toggle);
        int cyc = 0;
        while ((q.size() != 0 || busy_o) && cyc < 300) begin
            @(posedge clk); #1;
            if (toggle) out_ready_i = ~out_ready_i;
            cyc++;
        end
        chk("run_timeout", (cyc < 300), 1);
        out_ready_i = 1'b1;
        chk("queue_drained", q.size(), 0);
        chk("busy_after_run", busy_o, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int n);
        int cyc = 0;
        while (beats_seen < n && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wait_beats_timeout", (cyc < 100), 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_filt"},  filt_addr_o, 0);
        chk({tag, "_ifmap"}, ifmap_addr_o, 0);
        chk({tag, "_psum"},  psum_addr_o, 0);
        chk({tag, "_af"},    acc_first_o, 0);
        chk({tag, "_al"},    acc_last_o, 0);
    endtask

    // monitor: compare presented command to scoreboard head; pop on beat
    always @(negedge clk) begin
        if (!rstn) begin
            fin_prev = 1'b0;
        end else begin
            if (fin_prev || done_o) chk("done_pulse", done_o, fin_prev);
            fin_prev = 1'b0;
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", out_valid_o, 0);
                end else begin
                    chk("filt_addr",  filt_addr_o,  q[0].filt);
                    chk("ifmap_addr", ifmap_addr_o, q[0].ifmap);
                    chk("psum_addr",  psum_addr_o,  q[0].psum);
                    chk("acc_first",  acc_first_o,  q[0].af);
                    chk("acc_last",   acc_last_o,   q[0].al);
                    chk("busy_in_run", busy_o, 1);
                    if (out_ready_i && !abort_r) begin
                        beats_seen++;
                        fin_prev = q[0].fin;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: nominal 12-beat schedule, ready always high
        push_std();
        do_start(4'd2, 4'd1, 4'd1, 8'd16);
        run_to_idle(1'b0);

        // 2: same schedule with ready toggling every cycle
        push_std();
        out_ready_i = 1'b0;
        do_start(4'd2, 4'd1, 4'd1, 8'd16);
        run_to_idle(1'b1);

        // 3: all bounds zero -> single beat
        push_one_beat();
        do_start(4'd0, 4'd0, 4'd0, 8'd16);
        run_to_idle(1'b0);

        // 4: restart attempt with different cfg mid-run is ignored
        push_std();
        do_start(4'd2, 4'd1, 4'd1, 8'd16);
        @(posedge clk); #1;
        cfg_k_last_i = 4'd0; cfg_c_last_i = 4'd3; cfg_p_last_i = 4'd0; cfg_ifw_i = 8'd5;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        run_to_idle(1'b0);

        // 5: reset after beat 5, then a fresh full run
        push_std();
        beats_seen = 0;
        do_start(4'd2, 4'd1, 4'd1, 8'd16);
        wait_beats(5);
        rstn = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready_i = 1'b1;
        q.delete();
        chk_idle_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_o, 0);
        push_std();
        do_start(4'd2, 4'd1, 4'd1, 8'd16);
        run_to_idle(1'b0);

`ifdef PE_SEQ_ABORT_EN
        // 6: abort while beat 4 is offered; no done, then full run
        push_std();
        beats_seen = 0;
        do_start(4'd2, 4'd1, 4'd1, 8'd16);
        wait_beats(3);
        abort_r = 1'b1;
        @(posedge clk); #1;
        abort_r = 1'b0;
        chk("abort_beats", beats_seen, 3);
        q.delete();
        chk_idle_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        chk("abort_still_idle", busy_o, 0);
        push_std();
        do_start(4'd2, 4'd1, 4'd1, 8'd16);
        run_to_idle(1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
